// File: rtl/miner_csr_slave_if.sv
// Avalon-MM slave bus bundle between the HPS lightweight bridge and miner_csr_slave.
//   avs_address       word address (5 bits)
//   avs_read          read strobe, one cycle
//   avs_write         write strobe, one cycle
//   avs_writedata     write data (32 bits)
//   avs_readdata      read data, qualified by avs_readdatavalid
//   avs_readdatavalid read data valid, one cycle after avs_read
interface miner_csr_slave_if;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/miner_csr_slave.sv
// Host-side register slave for sha3_256_miner.
// Holds header/difficulty/start_nonce/control for the miner, returns solution,
// status and elapsed cycle count, and turns a miner irq rising edge into a
// maskable, host-clearable interrupt.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   avs                  Avalon-MM slave bus (miner_csr_slave_if.slave)
//   irq_out              level interrupt to host = PENDING & ENABLE
//   miner_header         256-bit header to miner
//   miner_difficulty     256-bit difficulty to miner
//   miner_start_nonce    64-bit start nonce to miner
//   miner_control        19-bit control to miner (bit0 = run)
//   miner_solution       64-bit solution from miner
//   miner_status         {test, run, found} from miner
//   miner_irq            found indication from miner
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | miner stopped, data registers writable
// ST_RUN   | miner running, ELAPSED counting
// ST_FOUND | miner irq edge seen, ELAPSED frozen
module miner_csr_slave #(
    parameter logic [7:0] PADF_RST = 8'h06,
    parameter logic [7:0] PADL_RST = 8'h80
) (
    input  logic                 clk,
    input  logic                 rst,
    miner_csr_slave_if.slave     avs,
    output logic                 irq_out,
    output logic [255:0]         miner_header,
    output logic [255:0]         miner_difficulty,
    output logic [63:0]          miner_start_nonce,
    output logic [18:0]          miner_control,
    input  logic [63:0]          miner_solution,
    input  logic [2:0]           miner_status,
    input  logic                 miner_irq
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FOUND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        irq_q;
    logic        pending, enable, lockerr;
    logic [63:0] elapsed;
    logic [31:0] sol_shadow, ela_shadow;
    logic [31:0] rdata;

    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        wr, rd, ctrl_wr, data_wr, irq_edge;

    assign addr     = avs.avs_address;
    assign wdata    = avs.avs_writedata;
    assign wr       = avs.avs_write;
    assign rd       = avs.avs_read;
    assign ctrl_wr  = wr && (addr == 5'h12);
    // 0x00-0x11 are the miner input registers, frozen while the miner runs
    assign data_wr  = wr && (addr < 5'h12);
    assign irq_edge = miner_irq && !irq_q;
    assign irq_out  = pending && enable;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_wr && !wdata[0]) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (ctrl_wr && wdata[0]) state_d = ST_RUN;
                ST_RUN:   if (irq_edge)            state_d = ST_FOUND;
                ST_FOUND: state_d = ST_FOUND;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (addr[4:3] == 2'b00) begin
            rdata = miner_header[{addr[2:0], 5'b0} +: 32];
        end else if (addr[4:3] == 2'b01) begin
            rdata = miner_difficulty[{addr[2:0], 5'b0} +: 32];
        end else begin
            case (addr)
                5'h10:   rdata = miner_start_nonce[31:0];
                5'h11:   rdata = miner_start_nonce[63:32];
                5'h12:   rdata = {13'h0, miner_control};
                5'h13:   rdata = {24'h0, lockerr, state_q, pending, 1'b0, miner_status};
                5'h14:   rdata = miner_solution[31:0];
                5'h15:   rdata = sol_shadow;
                5'h16:   rdata = {30'h0, enable, pending};
                5'h17:   rdata = elapsed[31:0];
                5'h18:   rdata = ela_shadow;
                default: rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miner_header          <= '0;
            miner_difficulty      <= '0;
            miner_start_nonce     <= '0;
            miner_control         <= {PADF_RST, PADL_RST, 3'b000};
            irq_q                 <= 1'b0;
            pending               <= 1'b0;
            enable                <= 1'b0;
            lockerr               <= 1'b0;
            elapsed               <= '0;
            sol_shadow            <= '0;
            ela_shadow            <= '0;
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            irq_q <= miner_irq;

            if (data_wr) begin
                if (miner_control[0]) begin
                    lockerr <= 1'b1;
                end else begin
                    case (addr[4:3])
                        2'b00:   miner_header[{addr[2:0], 5'b0} +: 32]     <= wdata;
                        2'b01:   miner_difficulty[{addr[2:0], 5'b0} +: 32] <= wdata;
                        default: begin
                            if (addr[0]) miner_start_nonce[63:32] <= wdata;
                            else         miner_start_nonce[31:0]  <= wdata;
                        end
                    endcase
                end
            end

            if (ctrl_wr) begin
                miner_control <= wdata[18:0];
                if (!wdata[0]) lockerr <= 1'b0;
            end

            if (wr && (addr == 5'h16)) begin
                enable <= wdata[1];
                if (wdata[0]) pending <= 1'b0;
            end
            // a new edge must never be lost to a racing clear
            if (irq_edge) pending <= 1'b1;

            if (state_q == ST_IDLE && state_d == ST_RUN)
                elapsed <= '0;
            else if (state_q == ST_RUN && elapsed != '1)
                elapsed <= elapsed + 64'd1;

            avs.avs_readdatavalid <= rd;
            if (rd) begin
                avs.avs_readdata <= rdata;
                // lo-half reads capture the hi half so a 2-word read is coherent
                if (addr == 5'h14) sol_shadow <= miner_solution[63:32];
                if (addr == 5'h17) ela_shadow <= elapsed[63:32];
            end
        end
    end
endmodule

// File: tb/tb_miner_csr_slave.sv
module tb_miner_csr_slave;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         irq_out;
    logic [255:0] miner_header;
    logic [255:0] miner_difficulty;
    logic [63:0]  miner_start_nonce;
    logic [18:0]  miner_control;
    logic [63:0]  miner_solution = '0;
    logic [2:0]   miner_status = '0;
    logic         miner_irq = 1'b0;

    miner_csr_slave_if bus ();

    miner_csr_slave dut (
        .clk               (clk),
        .rst               (rst),
        .avs               (bus.slave),
        .irq_out           (irq_out),
        .miner_header      (miner_header),
        .miner_difficulty  (miner_difficulty),
        .miner_start_nonce (miner_start_nonce),
        .miner_control     (miner_control),
        .miner_solution    (miner_solution),
        .miner_status      (miner_status),
        .miner_irq         (miner_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor: every readdatavalid must match the oldest expectation,
    // and arrive exactly on the cycle it was promised
    always @(negedge clk) begin
        if (bus.avs_readdatavalid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_readdatavalid: got data %h at cycle %0d, required no response", bus.avs_readdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.avs_readdata !== mon_e.data || cyc != mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL read_%02h: got %h at cycle %0d, required %h at cycle %0d",
                             mon_e.addr, bus.avs_readdata, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL read_%02h_missing: no readdatavalid at cycle %0d, required %h", mon_e.addr, mon_e.cyc, mon_e.data);
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // tasks enter and leave just after a falling edge
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        sb.push_back('{addr: a, data: exp, cyc: cyc + 1});
        @(negedge clk);
        bus.avs_read    = 1'b0;
    endtask

    task automatic bus_read_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        sb.push_back('{addr: a, data: exp, cyc: cyc + 1});
        @(negedge clk);
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_irq_out", 256'(irq_out), 256'h0);
        check("rst_readdatavalid", 256'(bus.avs_readdatavalid), 256'h0);
        check("rst_readdata", 256'(bus.avs_readdata), 256'h0);
        check("rst_control", 256'(miner_control), 256'h3400);
        check("rst_header", miner_header, 256'h0);
        bus_read(5'h12, 32'h0000_3400);
        bus_read(5'h13, 32'h0000_0000);
        bus_read(5'h16, 32'h0000_0000);
        bus_read(5'h1F, 32'h0000_0000);

        miner_status = 3'b010;

        // load header, start the miner
        for (int k = 0; k < 8; k++) bus_write(5'(k), 32'h1111_1111 * k);
        bus_write(5'h12, 32'h0000_3401);
        check("header_w0", 256'(miner_header[31:0]), 256'h0);
        check("header_w7", 256'(miner_header[255:224]), 256'h7777_7777);
        check("control_run", 256'(miner_control), 256'h3401);
        bus_read(5'h07, 32'h7777_7777);
        bus_read(5'h13, 32'h0000_0022);

        // lock while running
        bus_write(5'h08, 32'h0000_DEAD);
        bus_write(5'h10, 32'h0000_5555);
        check("locked_difficulty", miner_difficulty, 256'h0);
        check("locked_nonce", 256'(miner_start_nonce), 256'h0);
        bus_read(5'h13, 32'h0000_00A2);
        bus_write(5'h12, 32'h0000_3400);
        bus_read(5'h13, 32'h0000_0002);

        // unlocked again
        bus_write(5'h08, 32'h0000_DEAD);
        bus_write(5'h10, 32'h1234_5678);
        bus_write(5'h11, 32'h9ABC_DEF0);
        check("difficulty_w0", 256'(miner_difficulty[31:0]), 256'hDEAD);
        check("start_nonce", 256'(miner_start_nonce), 256'h9ABC_DEF0_1234_5678);
        bus_read(5'h11, 32'h9ABC_DEF0);

        // irq edge in RUN -> FOUND, ELAPSED frozen
        bus_write(5'h16, 32'h0000_0002);
        bus_write(5'h12, 32'h0000_3401);
        repeat (10) @(negedge clk);
        miner_irq = 1'b1;
        @(negedge clk);
        check("irq_out_set", 256'(irq_out), 256'h1);
        bus_read(5'h13, 32'h0000_0052);
        bus_read(5'h17, 32'd11);
        bus_read(5'h18, 32'd0);
        repeat (5) @(negedge clk);
        bus_read(5'h17, 32'd11);

        // W1C clears pending, enable written back as 1
        bus_write(5'h16, 32'h0000_0003);
        check("irq_out_cleared", 256'(irq_out), 256'h0);
        bus_read(5'h16, 32'h0000_0002);

        // set wins over same-cycle W1C
        miner_irq = 1'b0;
        @(negedge clk);
        miner_irq = 1'b1;
        bus_write(5'h16, 32'h0000_0003);
        check("irq_set_wins", 256'(irq_out), 256'h1);
        bus_read(5'h16, 32'h0000_0003);

        // FOUND does not go straight back to RUN
        bus_write(5'h12, 32'h0000_3401);
        bus_read(5'h13, 32'h0000_0052);
        bus_write(5'h12, 32'h0000_3400);
        bus_read(5'h13, 32'h0000_0012);
        bus_write(5'h16, 32'h0000_0001);
        check("irq_disabled", 256'(irq_out), 256'h0);
        bus_read(5'h16, 32'h0000_0000);

        // solution shadow
        miner_solution = 64'h0000_0001_FFFF_FFFF;
        bus_read(5'h14, 32'hFFFF_FFFF);
        miner_solution = 64'h0000_0002_0000_0000;
        bus_read(5'h15, 32'h0000_0001);
        bus_read(5'h14, 32'h0000_0000);
        bus_read(5'h15, 32'h0000_0002);

        // read + write same cycle returns the old value
        bus_read_write(5'h00, 32'hCAFE_F00D, 32'h0000_0000);
        bus_read(5'h00, 32'hCAFE_F00D);

        // CONTROL upper bits read as 0; unmapped writes ignored
        bus_write(5'h12, 32'hFFFF_FFFE);
        check("control_full", 256'(miner_control), 256'h7_FFFE);
        bus_read(5'h12, 32'h0007_FFFE);
        bus_write(5'h1A, 32'hFFFF_FFFF);
        bus_read(5'h1A, 32'h0000_0000);
        bus_read(5'h13, 32'h0000_0002);

        // reset during a read drops the response and stops the miner
        bus_write(5'h12, 32'h0000_3401);
        bus.avs_address = 5'h12;
        bus.avs_read    = 1'b1;
        rst             = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        rst             = 1'b0;
        check("rst_drops_rdv", 256'(bus.avs_readdatavalid), 256'h0);
        check("rst_stops_miner", 256'(miner_control), 256'h3400);
        bus_read(5'h13, 32'h0000_0002);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d outstanding reads, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
